// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
//   - hz_state_e : sequencer states (IDLE / STALL / FLUSH)
//   - parameter defaults for flush and load-stall lengths
//   - REG_ZERO   : architectural x0, never a real dependency
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE  = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_e;

  localparam int unsigned FLUSH_CYCLES_DEF      = 1;
  localparam int unsigned LOAD_STALL_CYCLES_DEF = 1;
  localparam logic [4:0]  REG_ZERO              = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
//   Datapath -> controller: branch_taken_mem, id_ex_mem_read, id_ex_rd,
//                           if_id_rs1/rs2, if_id_uses_rs1/rs2
//   Controller -> datapath: pc_write_en, if_id_write_en, if_id_flush,
//                           id_ex_flush, ex_mem_flush, busy,
//                           stall_cnt, flush_cnt
// master = datapath side, slave = controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             branch_taken_mem;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rd;
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             if_id_uses_rs1;
  logic             if_id_uses_rs2;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output branch_taken_mem, id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
           if_id_uses_rs1, if_id_uses_rs2,
    input  pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_flush,
           busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  branch_taken_mem, id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
           if_id_uses_rs1, if_id_uses_rs2,
    output pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_flush,
           busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector.
//   Inputs : ID/EX load flag and destination, IF/ID source registers and
//            their use flags.
//   Output : hazard - IF/ID reads a register the ID/EX load has not yet
//            produced (x0 never counts).
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rd,
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic       if_id_uses_rs1,
  input  logic       if_id_uses_rs2,
  output logic       hazard
);

  always_comb begin
    hazard = id_ex_mem_read && (id_ex_rd != REG_ZERO) &&
             ((if_id_uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
              (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   hz (slave) : hazard sources in, write enables / flushes / busy and
//                wrapping stall and flush performance counters out
// Control outputs are Mealy: a hazard or taken branch acts in the cycle it
// is seen. A taken branch outranks a load-use hazard except while already
// flushing, where both inputs come from wrong-path instructions.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES      = FLUSH_CYCLES_DEF,
  parameter int unsigned LOAD_STALL_CYCLES = LOAD_STALL_CYCLES_DEF,
  parameter int unsigned CNT_W             = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] STALL_LAST = 4'(LOAD_STALL_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic pc_write_en, if_id_write_en, flush_all, id_ex_flush, busy;

  load_use_detect u_load_use_detect (
    .id_ex_mem_read (hz.id_ex_mem_read),
    .id_ex_rd       (hz.id_ex_rd),
    .if_id_rs1      (hz.if_id_rs1),
    .if_id_rs2      (hz.if_id_rs2),
    .if_id_uses_rs1 (hz.if_id_uses_rs1),
    .if_id_uses_rs2 (hz.if_id_uses_rs2),
    .hazard         (hazard)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    flush_all      = 1'b0;
    id_ex_flush    = 1'b0;
    busy           = (state_q != HZ_IDLE);

    if (reset) begin
      // Flushing during reset clears every pipeline register.
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      flush_all      = 1'b1;
      busy           = 1'b0;
    end else if (state_q == HZ_FLUSH) begin
      flush_all = 1'b1;
      if (cnt_q == FLUSH_LAST) begin
        state_d = HZ_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (hz.branch_taken_mem) begin
      // From IDLE or STALL: a taken branch aborts any stall in progress.
      flush_all   = 1'b1;
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
      if (FLUSH_CYCLES > 1) begin
        state_d = HZ_FLUSH;
        cnt_d   = 4'd1;
      end else begin
        state_d = HZ_IDLE;
        cnt_d   = '0;
      end
    end else if (state_q == HZ_STALL) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
      stall_cnt_d    = stall_cnt_q + CNT_W'(1);
      if (cnt_q == STALL_LAST) begin
        state_d = HZ_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (hazard) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
      stall_cnt_d    = stall_cnt_q + CNT_W'(1);
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = HZ_STALL;
        cnt_d   = 4'd1;
      end else begin
        state_d = HZ_IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HZ_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_write_en    = pc_write_en;
  assign hz.if_id_write_en = if_id_write_en;
  assign hz.if_id_flush    = flush_all;
  assign hz.id_ex_flush    = flush_all | id_ex_flush;
  assign hz.ex_mem_flush   = flush_all;
  assign hz.busy           = busy;
  assign hz.stall_cnt      = stall_cnt_q;
  assign hz.flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl. Two instances:
//   dut_a : FLUSH_CYCLES=1, LOAD_STALL_CYCLES=1
//   dut_b : FLUSH_CYCLES=3, LOAD_STALL_CYCLES=3
// Each stimulus step drives one instance just after the rising edge and
// queues the hand-computed outputs expected for that cycle; the monitor
// samples on the falling edge and compares.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) if_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(32)) if_b ();

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .LOAD_STALL_CYCLES(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(rst_a), .hz(if_a.slave)
  );
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(3), .CNT_W(32)) dut_b (
    .clk(clk), .reset(rst_b), .hz(if_b.slave)
  );

  // ctrl = {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_flush, busy}
  localparam logic [5:0] RST = 6'b00_111_0;
  localparam logic [5:0] IDL = 6'b11_000_0;
  localparam logic [5:0] STI = 6'b00_010_0;  // stall, entered from IDLE
  localparam logic [5:0] STS = 6'b00_010_1;  // stall, in STALL state
  localparam logic [5:0] BRI = 6'b11_111_0;  // branch seen in IDLE
  localparam logic [5:0] BRS = 6'b11_111_1;  // branch in STALL, or FLUSH state

  typedef struct {
    bit          sel;
    logic [5:0]  ctrl;
    logic [31:0] s;
    logic [31:0] f;
    int          id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  task automatic idle_inputs();
    if_a.branch_taken_mem = 0; if_a.id_ex_mem_read = 0; if_a.id_ex_rd = '0;
    if_a.if_id_rs1 = '0; if_a.if_id_rs2 = '0; if_a.if_id_uses_rs1 = 0; if_a.if_id_uses_rs2 = 0;
    if_b.branch_taken_mem = 0; if_b.id_ex_mem_read = 0; if_b.id_ex_rd = '0;
    if_b.if_id_rs1 = '0; if_b.if_id_rs2 = '0; if_b.if_id_uses_rs1 = 0; if_b.if_id_uses_rs2 = 0;
  endtask

  task automatic step(input bit sel, input bit rst, input bit br, input bit mr,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2,
                      input logic [5:0] ctrl, input logic [31:0] s, input logic [31:0] f);
    exp_t e;
    @(posedge clk);
    #1;
    idle_inputs();
    rst_a = 0;
    rst_b = 0;
    if (!sel) begin
      rst_a = rst;
      if_a.branch_taken_mem = br; if_a.id_ex_mem_read = mr; if_a.id_ex_rd = rd;
      if_a.if_id_rs1 = rs1; if_a.if_id_rs2 = rs2; if_a.if_id_uses_rs1 = u1; if_a.if_id_uses_rs2 = u2;
    end else begin
      rst_b = rst;
      if_b.branch_taken_mem = br; if_b.id_ex_mem_read = mr; if_b.id_ex_rd = rd;
      if_b.if_id_rs1 = rs1; if_b.if_id_rs2 = rs2; if_b.if_id_uses_rs1 = u1; if_b.if_id_uses_rs2 = u2;
    end
    e.sel = sel; e.ctrl = ctrl; e.s = s; e.f = f; e.id = step_no;
    q.push_back(e);
    step_no++;
  endtask

  // Monitor: compares the oldest queued expectation each falling edge.
  initial begin
    exp_t        e;
    logic [5:0]  act_ctrl;
    logic [31:0] act_s, act_f;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.sel) begin
          act_ctrl = {if_b.pc_write_en, if_b.if_id_write_en, if_b.if_id_flush,
                      if_b.id_ex_flush, if_b.ex_mem_flush, if_b.busy};
          act_s = if_b.stall_cnt; act_f = if_b.flush_cnt;
        end else begin
          act_ctrl = {if_a.pc_write_en, if_a.if_id_write_en, if_a.if_id_flush,
                      if_a.id_ex_flush, if_a.ex_mem_flush, if_a.busy};
          act_s = if_a.stall_cnt; act_f = if_a.flush_cnt;
        end
        checks++;
        if (act_ctrl !== e.ctrl || act_s !== e.s || act_f !== e.f) begin
          errors++;
          $display("FAIL step%0d dut_%s: got ctrl=%b stall=%0d flush=%0d, expected ctrl=%b stall=%0d flush=%0d",
                   e.id, e.sel ? "b" : "a", act_ctrl, act_s, act_f, e.ctrl, e.s, e.f);
        end
      end
    end
  end

  initial begin
    rst_a = 1; rst_b = 1;
    idle_inputs();
    repeat (2) @(posedge clk);

    // dut_a: reset, then load-use and branch cases
    //    sel rst br mr rd  rs1 rs2 u1 u2  ctrl s  f
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0, 0);
    step(0, 0, 0, 1, 5, 0, 5, 0, 1, STI, 0, 0);  // rs2 load-use
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 1, 0);  // single stall cycle only
    step(0, 0, 0, 1, 0, 0, 0, 1, 1, IDL, 1, 0);  // rd = x0: no hazard
    step(0, 0, 0, 1, 7, 7, 0, 1, 0, STI, 1, 0);  // rs1 load-use
    step(0, 0, 0, 1, 7, 7, 0, 0, 0, IDL, 2, 0);  // rs1 matches but unused
    step(0, 0, 1, 1, 5, 0, 5, 0, 1, BRI, 2, 0);  // branch beats hazard
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 2, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, BRI, 2, 1);  // 1-cycle flush
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 2, 2);

    // dut_b: 3-cycle flush, second branch ignored
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, BRI, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, BRS, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, BRS, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0, 1);
    // stall aborted by branch in second stall cycle
    step(1, 0, 0, 1, 3, 3, 0, 1, 0, STI, 0, 1);
    step(1, 0, 1, 1, 3, 3, 0, 1, 0, BRS, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, BRS, 1, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, BRS, 1, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 1, 2);
    // full 3-cycle stall; hazard held in STALL is ignored
    step(1, 0, 0, 1, 9, 0, 9, 0, 1, STI, 1, 2);
    step(1, 0, 0, 1, 9, 0, 9, 0, 1, STS, 2, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, STS, 3, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 4, 2);
    // reset during flush cycle 1 of 3
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, BRI, 4, 2);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, RST, 4, 3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0, 0);

    @(posedge clk);
    #1;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It detects load-use hazards between ID/EX and IF/ID and stalls the front end. It also detects branches taken in MEM (EX_MEM PC_src) and flushes the wrong-path instructions held in IF_ID, ID_EX and EX_MEM. It drives the PC, IF_ID and ID_EX write enables and the is_flush inputs of every pipeline register, so per-register flush counting is no longer needed.

Parameters:
FLUSH_CYCLES, 1, cycles all flush outputs stay high per taken branch (1..15)
LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (1..15)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high
branch_taken_mem  in  1  PC_src output of EX_MEM (branch resolved taken in MEM)
id_ex_mem_read  in  1  instruction in ID/EX is a load
id_ex_rd  in  5  destination register of ID/EX
if_id_rs1  in  5  rs1 of instruction in IF/ID
if_id_rs2  in  5  rs2 of instruction in IF/ID
if_id_uses_rs1  in  1  IF/ID instruction reads rs1
if_id_uses_rs2  in  1  IF/ID instruction reads rs2
pc_write_en  out  1  PC register update enable
if_id_write_en  out  1  IF_ID register load enable
if_id_flush  out  1  is_flush to IF_ID
id_ex_flush  out  1  is_flush to ID_EX (also used to inject the bubble)
ex_mem_flush  out  1  is_flush to EX_MEM
busy  out  1  FSM not in IDLE
stall_cnt  out  CNT_W  total stall cycles since reset, wraps
flush_cnt  out  CNT_W  total taken-branch flush events since reset, wraps

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- hazard = id_ex_mem_read && id_ex_rd!=0 && ((if_id_uses_rs1 && if_id_rs1==id_ex_rd) || (if_id_uses_rs2 && if_id_rs2==id_ex_rd)). Implemented combinationally.
- States: IDLE, STALL, FLUSH. There is a 4-bit counter cnt. Control outputs are Mealy: they react in the same cycle the condition is seen, with zero latency.
- While reset=1, regardless of other inputs:
  - all three flushes = 1; pc_write_en = 0; if_id_write_en = 0; busy = 0.
  - On the clock edge: state <= IDLE, cnt <= 0, stall_cnt <= 0, flush_cnt <= 0.
  - Pipeline registers are therefore cleared through flush during reset.
- Default outputs in IDLE with no event: write enables = 1, flushes = 0.
- Priority: branch_taken_mem > hazard. This holds in every state except FLUSH.
- IDLE + branch_taken_mem:
  - All three flushes = 1 this cycle; pc_write_en = 1 (PC takes the branch target); flush_cnt += 1.
  - Next state is FLUSH with cnt=1 if FLUSH_CYCLES>1, else IDLE.
- IDLE + hazard (no branch):
  - pc_write_en = 0, if_id_write_en = 0, id_ex_flush = 1; stall_cnt += 1.
  - Next state is STALL with cnt=1 if LOAD_STALL_CYCLES>1, else IDLE.
- STALL:
  - Same outputs as the IDLE hazard case; stall_cnt += 1. The hazard input is ignored here (the bubble is already in ID/EX).
  - cnt increments; go to IDLE when cnt==LOAD_STALL_CYCLES-1.
  - If branch_taken_mem=1 in STALL: branch behaviour applies and the stall is aborted. This cycle uses IDLE+branch outputs and counts, and stall_cnt is not incremented. Next state is FLUSH or IDLE per FLUSH_CYCLES.
- FLUSH:
  - All flushes = 1; pc_write_en = 1; if_id_write_en = 1.
  - branch_taken_mem and hazard are ignored, because they come from wrong-path instructions.
  - cnt increments; go to IDLE when cnt==FLUSH_CYCLES-1.
- busy = (state != IDLE).
- Counters wrap modulo 2^CNT_W. cnt resets to 0 on every entry to IDLE.
- Reset asserted mid-STALL or mid-FLUSH aborts the sequence immediately and applies the reset outputs.

Decomposition:
- defs.v gains: state encodings HZ_IDLE=2'd0, HZ_STALL=2'd1, HZ_FLUSH=2'd2; `FLUSH_CYCLES_DEF and `LOAD_STALL_CYCLES_DEF (parameter defaults); `REG_ZERO=5'd0.
- One combinational sub-module, load_use_detect, computes hazard from the id_ex_* and if_id_* inputs so it can be tested standalone. The FSM, cnt and the performance counters stay in pipeline_hazard_ctrl.

Test Plan:
1. Reset held 2 cycles, then released -> during reset all flushes=1 and write enables=0; after release busy=0, stall_cnt=0, flush_cnt=0, flushes=0, write enables=1.
2. Load-use: id_ex_mem_read=1, id_ex_rd=5, if_id_rs2=5, uses_rs2=1 (LOAD_STALL_CYCLES=1) -> pc_write_en=0, if_id_write_en=0 and id_ex_flush=1 for exactly 1 cycle; stall_cnt=1. Same test with id_ex_rd=0 -> no stall.
3. Taken branch with FLUSH_CYCLES=3: branch_taken_mem=1 for 1 cycle, then 1 again in cycle 2 -> flushes high for cycles 0-2 only; flush_cnt=1; busy high in cycles 1-2; the second branch is ignored.
4. Simultaneous branch_taken_mem=1 and hazard=1 -> flush behaviour only: pc_write_en=1, stall_cnt unchanged, flush_cnt=1.
5. LOAD_STALL_CYCLES=3, with branch_taken_mem=1 arriving in the second stall cycle -> stall aborted: that cycle pc_write_en=1 and all flushes=1; stall_cnt=1.
6. Reset asserted in FLUSH cycle 1 of 3 -> next cycle state=IDLE, counters=0, no further flush after reset is released.
